// File: rtl/core_pkg.sv
// Shared definitions for the 16-bit pipelined core: result-select encoding,
// memory-mapped IO addresses and the MEM/WB pipeline record.
package core_pkg;

  localparam logic [1:0] RES_ALU = 2'b00;
  localparam logic [1:0] RES_MEM = 2'b01;
  localparam logic [1:0] RES_PC2 = 2'b10;

  localparam logic [15:0] IO_DATA_ADDR   = 16'hFF00;
  localparam logic [15:0] IO_STATUS_ADDR = 16'hFF01;

  // Source of readDataW, decided in MEM and carried alongside the load.
  typedef enum logic [1:0] {
    RD_ZERO,
    RD_RAM,
    RD_STATUS
  } rd_sel_e;

  typedef struct packed {
    logic        regWrite;
    logic [1:0]  resultSrc;
    logic [15:0] aluRes;
    logic [15:0] PCPlus2;
    logic [3:0]  Rd;
  } mem_wb_t;

endpackage

// File: rtl/io_fifo.sv
// Output-port FIFO: registered head/valid, push ignored when full,
// pop ignored when empty, pointers wrap modulo FIFO_DEPTH.
module io_fifo #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic [15:0] push_data,
  input  logic        pop,
  output logic [15:0] head,
  output logic        valid,
  output logic        full,
  output logic        empty
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW + 1)'(FIFO_DEPTH);

  logic [15:0]   mem [FIFO_DEPTH];
  logic [PW-1:0] wrPtr;
  logic [PW-1:0] rdPtr;
  logic [PW:0]   count;
  logic          doPush;
  logic          doPop;

  assign full   = (count == FULL_CNT);
  assign empty  = (count == '0);
  assign valid  = !empty;
  assign head   = mem[rdPtr];
  assign doPush = push && !full;
  assign doPop  = pop && !empty;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: storage arrays are deliberately left out of reset; the pointers
  // and count alone define which entries are live.
  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= push_data;
  end

endmodule

// File: rtl/memory_stage.sv
// MEM stage: word-addressed data RAM, memory-mapped output FIFO and the
// MEM/WB pipeline register; stalls a store that targets a full FIFO.
module memory_stage
  import core_pkg::*;
#(
  parameter int DEPTH      = 256,
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        regWriteM,
  input  logic        memWriteM,
  input  logic [1:0]  resultSrcM,
  input  logic [15:0] PCPlus2M,
  input  logic [15:0] aluResM,
  input  logic [15:0] writeDataM,
  input  logic [3:0]  RdM,
  output logic        regWriteW,
  output logic [1:0]  resultSrcW,
  output logic [15:0] aluResW,
  output logic [15:0] readDataW,
  output logic [15:0] PCPlus2W,
  output logic [3:0]  RdW,
  output logic        stallM,
  output logic [15:0] io_data,
  output logic        io_valid,
  input  logic        io_ready
);

  localparam int AW = $clog2(DEPTH);

  logic [15:0] ram [DEPTH];
  logic [15:0] ramQ;
  logic [AW-1:0] ramIdx;
  logic        ramSel;
  logic        isIoData;
  logic        isIoStatus;
  logic        push;
  logic        ramWe;
  logic        fifoFull;
  logic        fifoEmpty;

  mem_wb_t     wb;
  rd_sel_e     rdSel;
  logic [1:0]  statusQ;

  assign ramSel     = ({1'b0, aluResM} < 17'(DEPTH));
  assign ramIdx     = aluResM[AW-1:0];
  assign isIoData   = (aluResM == IO_DATA_ADDR);
  assign isIoStatus = (aluResM == IO_STATUS_ADDR);
  assign push       = memWriteM && isIoData;
  // Depends only on registered FIFO state, never on io_ready.
  assign stallM     = push && fifoFull && !rst;
  assign ramWe      = memWriteM && ramSel && !stallM && !rst;

  io_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_io_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_data(writeDataM),
    .pop      (io_ready),
    .head     (io_data),
    .valid    (io_valid),
    .full     (fifoFull),
    .empty    (fifoEmpty)
  );

  // Read-before-write: a same-address store is not visible to this read.
  always_ff @(posedge clk) begin
    if (ramWe) ram[ramIdx] <= writeDataM;
    ramQ <= ram[ramIdx];
  end

  always_ff @(posedge clk) begin
    if (rst || stallM) begin
      wb      <= '0;
      rdSel   <= RD_ZERO;
      statusQ <= '0;
    end else begin
      wb.regWrite  <= regWriteM;
      wb.resultSrc <= resultSrcM;
      wb.aluRes    <= aluResM;
      wb.PCPlus2   <= PCPlus2M;
      wb.Rd        <= RdM;
      rdSel        <= ramSel ? RD_RAM : (isIoStatus ? RD_STATUS : RD_ZERO);
      statusQ      <= {fifoFull, fifoEmpty};
    end
  end

  // NOTE: always_comb outputs get a default first so no path infers a latch.
  always_comb begin
    readDataW = '0;
    case (rdSel)
      RD_RAM:    readDataW = ramQ;
      RD_STATUS: readDataW = {14'b0, statusQ};
      default:   readDataW = '0;
    endcase
  end

  assign regWriteW  = wb.regWrite;
  assign resultSrcW = wb.resultSrc;
  assign aluResW    = wb.aluRes;
  assign PCPlus2W   = wb.PCPlus2;
  assign RdW        = wb.Rd;

endmodule

// File: tb/tb_memory_stage.sv
// Scoreboard bench for memory_stage: a queue/array reference model predicts
// each cycle's stall and WB record; a negedge monitor compares them.
module tb_memory_stage;
  import core_pkg::*;

  localparam int DEPTH = 256;
  localparam int FD    = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        regWriteM, memWriteM;
  logic [1:0]  resultSrcM;
  logic [15:0] PCPlus2M, aluResM, writeDataM;
  logic [3:0]  RdM;
  logic        regWriteW;
  logic [1:0]  resultSrcW;
  logic [15:0] aluResW, readDataW, PCPlus2W;
  logic [3:0]  RdW;
  logic        stallM;
  logic [15:0] io_data;
  logic        io_valid;
  logic        io_ready;

  always #5 clk = ~clk;

  memory_stage #(.DEPTH(DEPTH), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .rst(rst),
    .regWriteM(regWriteM), .memWriteM(memWriteM), .resultSrcM(resultSrcM),
    .PCPlus2M(PCPlus2M), .aluResM(aluResM), .writeDataM(writeDataM), .RdM(RdM),
    .regWriteW(regWriteW), .resultSrcW(resultSrcW), .aluResW(aluResW),
    .readDataW(readDataW), .PCPlus2W(PCPlus2W), .RdW(RdW),
    .stallM(stallM), .io_data(io_data), .io_valid(io_valid), .io_ready(io_ready)
  );

  typedef struct {
    logic        regWrite;
    logic [1:0]  resultSrc;
    logic [15:0] aluRes;
    logic [15:0] readData;
    logic [15:0] PCPlus2;
    logic [3:0]  Rd;
    bit          chkRead;
  } wb_exp_t;

  typedef struct {
    bit stall;
    bit ioValid;
    bit chkIo;
  } m_exp_t;

  wb_exp_t     wbQ[$];
  m_exp_t      mQ[$];
  logic [15:0] ioQ[$];
  logic [15:0] fifoM[$];
  logic [15:0] ramM [DEPTH];
  bit          ramKnown [DEPTH];
  int          nTests = 0;
  int          nFail  = 0;
  bit          lastStall = 1'b0;

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One pipeline cycle: drive inputs, predict, take the edge, update model.
  task automatic cyc(input bit r, input logic rw, input logic mw, input logic [1:0] rs,
                     input logic [15:0] pc, input logic [15:0] alu, input logic [15:0] wd,
                     input logic [3:0] rd, input bit rdy);
    int      n;
    bit      isPush, full, stall;
    wb_exp_t w;
    m_exp_t  m;
    rst = r; regWriteM = rw; memWriteM = mw; resultSrcM = rs; PCPlus2M = pc;
    aluResM = alu; writeDataM = wd; RdM = rd; io_ready = rdy;

    n      = fifoM.size();
    full   = (n == FD);
    isPush = mw && (alu == IO_DATA_ADDR);
    stall  = !r && isPush && full;
    m.stall = stall; m.ioValid = (n != 0); m.chkIo = !r;
    mQ.push_back(m);

    w = '{default: '0};
    w.chkRead = 1'b1;
    if (!r && !stall) begin
      w.regWrite = rw; w.resultSrc = rs; w.aluRes = alu; w.PCPlus2 = pc; w.Rd = rd;
      if (int'(alu) < DEPTH) begin
        w.readData = ramM[alu];
        w.chkRead  = ramKnown[alu];
      end else if (alu == IO_STATUS_ADDR) begin
        w.readData = {14'b0, full, n == 0};
      end
    end
    lastStall = stall;

    @(posedge clk);
    if (r) begin
      fifoM.delete();
      ioQ.delete();
    end else begin
      if (rdy && n > 0) void'(fifoM.pop_front());
      if (isPush && !full) begin
        fifoM.push_back(wd);
        ioQ.push_back(wd);
      end
      if (mw && int'(alu) < DEPTH) begin
        ramM[alu]     = wd;
        ramKnown[alu] = 1'b1;
      end
    end
    #1 wbQ.push_back(w);
  endtask

  task automatic nop(input bit rdy);
    cyc(0, 0, 0, RES_ALU, 16'h0, 16'h0, 16'h0, 4'h0, rdy);
  endtask

  task automatic ioStore(input logic [15:0] v, input bit rdy);
    cyc(0, 0, 1, RES_ALU, 16'h0, IO_DATA_ADDR, v, 4'h0, rdy);
  endtask

  // Monitor: mid-cycle, inputs stable and the previous edge's results visible.
  m_exp_t  mm;
  wb_exp_t ww;
  always @(negedge clk) begin
    if (mQ.size() > 0) begin
      mm = mQ.pop_front();
      check("stallM", {15'b0, stallM}, {15'b0, mm.stall});
      if (mm.chkIo) check("io_valid", {15'b0, io_valid}, {15'b0, mm.ioValid});
    end
    if (wbQ.size() > 0) begin
      ww = wbQ.pop_front();
      check("regWriteW",  {15'b0, regWriteW}, {15'b0, ww.regWrite});
      check("resultSrcW", {14'b0, resultSrcW}, {14'b0, ww.resultSrc});
      check("aluResW",    aluResW,  ww.aluRes);
      check("PCPlus2W",   PCPlus2W, ww.PCPlus2);
      check("RdW",        {12'b0, RdW}, {12'b0, ww.Rd});
      if (ww.chkRead) check("readDataW", readDataW, ww.readData);
    end
    if (rst === 1'b0 && io_valid === 1'b1 && io_ready === 1'b1) begin
      if (ioQ.size() == 0) begin
        nTests++;
        nFail++;
        $display("FAIL io_data: handshake with nothing expected, got %h", io_data);
      end else begin
        check("io_data", io_data, ioQ.pop_front());
      end
    end
  end

  initial begin
    logic        rw, mw, rdy;
    logic [1:0]  rs;
    logic [15:0] pc, alu, wd;
    logic [3:0]  rd;
    int          sel;

    rst = 1'b1; regWriteM = 0; memWriteM = 0; resultSrcM = 0; PCPlus2M = 0;
    aluResM = 0; writeDataM = 0; RdM = 0; io_ready = 0;
    @(posedge clk);
    #1;

    repeat (2)
      cyc(1, 1'($urandom), 1'($urandom), 2'($urandom_range(0, 2)), 16'($urandom),
          16'($urandom), 16'($urandom), 4'($urandom), 1'($urandom));

    // Status after reset, store/load, pass-through.
    cyc(0, 1, 0, RES_MEM, 16'h0, IO_STATUS_ADDR, 16'h0, 4'd1, 0);
    cyc(0, 0, 1, RES_ALU, 16'h0, 16'h0010, 16'hBEEF, 4'd0, 0);
    cyc(0, 1, 0, RES_MEM, 16'h0, 16'h0010, 16'h0, 4'd3, 0);
    cyc(0, 1, 0, RES_PC2, 16'h0042, 16'h1234, 16'h0, 4'd5, 0);
    cyc(0, 0, 1, RES_ALU, 16'h0, 16'h0000, 16'h5A5A, 4'd0, 0);

    // Fill, stall, single pop releases the held store, then drain.
    for (int i = 1; i <= 4; i++) ioStore(16'(i), 0);
    ioStore(16'd5, 0);
    ioStore(16'd5, 1);
    ioStore(16'd5, 0);
    cyc(0, 1, 0, RES_MEM, 16'h0, IO_STATUS_ADDR, 16'h0, 4'd2, 0);
    repeat (5) nop(1);

    // Simultaneous push/pop at count 2, ten values through the wrap.
    ioStore(16'd100, 0);
    ioStore(16'd101, 0);
    for (int i = 2; i < 10; i++) ioStore(16'(100 + i), 1);
    repeat (3) nop(1);

    // Unmapped address: store ignored, load returns 0, RAM[0] intact.
    cyc(0, 0, 1, RES_ALU, 16'h0, 16'h8000, 16'hAAAA, 4'd0, 0);
    cyc(0, 1, 0, RES_MEM, 16'h0, 16'h8000, 16'h0, 4'd4, 0);
    cyc(0, 1, 0, RES_MEM, 16'h0, 16'h0000, 16'h0, 4'd6, 0);

    // Reset while stalled.
    for (int i = 0; i < 4; i++) ioStore(16'(16'h0200 + i), 0);
    ioStore(16'h0299, 0);
    cyc(1, 0, 1, RES_ALU, 16'h0, IO_DATA_ADDR, 16'h0299, 4'd0, 0);
    ioStore(16'h0299, 0);
    repeat (2) nop(1);

    // Randomised traffic; a stalled instruction is held by upstream.
    rw = 0; mw = 0; rs = 0; pc = 0; alu = 0; wd = 0; rd = 0;
    for (int k = 0; k < 400; k++) begin
      if (!lastStall) begin
        sel = $urandom_range(0, 9);
        if (sel < 4)      alu = 16'($urandom_range(0, 15));
        else if (sel < 7) alu = IO_DATA_ADDR;
        else if (sel < 8) alu = IO_STATUS_ADDR;
        else              alu = 16'($urandom);
        rw = 1'($urandom); mw = 1'($urandom); rs = 2'($urandom_range(0, 2));
        pc = 16'($urandom); wd = 16'($urandom); rd = 4'($urandom);
      end
      rdy = ($urandom_range(0, 2) != 0);
      cyc(0, rw, mw, rs, pc, alu, wd, rd, rdy);
    end

    repeat (FD + 2) nop(1);
    @(negedge clk);
    #1;
    check("fifo drained", 16'(ioQ.size()), 16'd0);
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- MEM stage of the 16-bit pipelined core. It sits directly downstream of the execute stage and consumes its M-suffixed outputs.
- Contains the word-addressed data RAM, a memory-mapped output port backed by a small FIFO with valid/ready handshake, and the MEM/WB pipeline register feeding writeback.
- Raises a stall when a store targets a full output FIFO.

Parameters:
- DEPTH, 256, data RAM depth in 16-bit words (power of two).
- FIFO_DEPTH, 4, output FIFO entries (power of two, >=2).

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  reset, synchronous, active-high
- regWriteM  in  1  register write enable from execute
- memWriteM  in  1  store enable from execute
- resultSrcM  in  2  result select: 00 ALU, 01 memory, 10 PC+2
- PCPlus2M  in  16  PC+2 of the instruction
- aluResM  in  16  ALU result / effective address
- writeDataM  in  16  store data
- RdM  in  4  destination register
- regWriteW  out  1  registered regWrite to writeback
- resultSrcW  out  2  registered resultSrc
- aluResW  out  16  registered ALU result
- readDataW  out  16  load data, aligned with the other W outputs
- PCPlus2W  out  16  registered PC+2
- RdW  out  4  registered destination
- stallM  out  1  hold execute/MEM inputs this cycle
- io_data  out  16  FIFO head data
- io_valid  out  1  FIFO not empty
- io_ready  in  1  consumer accepts head when io_valid=1

Behaviour:
- Reset: all W outputs 0, stallM 0, FIFO empty (io_valid 0, pointers and count 0). io_data is don't-care while io_valid=0. RAM contents are not reset. Reset mid-operation discards FIFO contents and any pending store.
- Address map, decoded on aluResM:
  - aluResM < DEPTH: RAM, index aluResM[log2(DEPTH)-1:0].
  - 16'hFF00 IO_DATA: a store pushes into the FIFO; a load returns 0.
  - 16'hFF01 IO_STATUS: a load returns {14'b0, full, empty}; a store is ignored.
  - Any other address: stores are ignored, loads return 0.
- RAM write: on a clock edge when memWriteM=1, RAM selected and stallM=0.
- RAM read: synchronous. Address is sampled every cycle, and data appears on readDataW the next cycle, together with that instruction's other W outputs. Load latency is 1 cycle.
- Read-during-write to the same address returns the old data (no store-to-load bypass within MEM).
- MEM/WB register: when stallM=0 it captures all M inputs each cycle. When stallM=1 it loads a bubble: regWriteW=0, resultSrcW=00, others 0.
- push = memWriteM & (aluResM==IO_DATA).
- stallM = push & full (combinational). It does not depend on io_ready, so there is no ready-to-stall combinational path.
- FIFO:
  - Effective push when push & !full.
  - Pop when io_valid & io_ready.
  - Simultaneous push and pop: count unchanged, both pointers advance.
  - Pointers wrap modulo FIFO_DEPTH.
  - count is 0..FIFO_DEPTH; full = (count==FIFO_DEPTH); empty = (count==0).
  - A pop in a stalled cycle frees a slot. The stalled store then completes on the following cycle because upstream holds its inputs.
- io_data/io_valid are driven from registered FIFO state only.

Decomposition:
- Shared package core_pkg holds:
  - resultSrc encoding constants RES_ALU=2'b00, RES_MEM=2'b01, RES_PC2=2'b10
  - IO_DATA_ADDR=16'hFF00, IO_STATUS_ADDR=16'hFF01
- One sub-module io_fifo with parameter FIFO_DEPTH and ports clk, rst, push, push_data, pop, head, valid, full, empty.
- RAM stays inline in memory_stage as an inferred synchronous array.

Test Plan:
- Reset: rst=1 for 2 cycles with random inputs -> every W output 0, stallM=0, io_valid=0. After release, FIFO status load at 16'hFF01 returns 16'h0001.
- Store then load: store writeDataM=16'hBEEF at aluResM=16'h0010, next cycle load 16'h0010 with resultSrcM=01, RdM=3 -> readDataW=16'hBEEF, regWriteW=1, RdW=3 one cycle after the load is presented.
- Pass-through: regWriteM=1, resultSrcM=10, PCPlus2M=16'h0042, aluResM=16'h1234, RdM=5 -> next cycle regWriteW=1, resultSrcW=10, PCPlus2W=16'h0042, aluResW=16'h1234, RdW=5.
- FIFO fill/stall:
  - io_ready=0; stores of 1,2,3,4 to 16'hFF00 -> io_valid=1, io_data=1, no stall.
  - 5th store -> stallM=1 and the cycle's WB outputs are a bubble.
  - Raise io_ready for 1 cycle -> stall clears the next cycle and 5 is enqueued.
  - Drain order 2,3,4,5.
- Simultaneous push and pop at count=2 -> count stays 2, order preserved. After wrap-around (push 10 values total through depth 4), output order is exactly the input order.
- Unmapped address: store 16'hAAAA to 16'h8000, then load 16'h8000 -> readDataW=0, RAM[0] unchanged. Reset asserted mid-stall -> stallM=0 and FIFO empty next cycle.
